uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rr_picker.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and width constants for the UART transmit arbiter.
package uart_pkg;
  localparam int UART_BYTE_W   = 8;
  localparam int UART_ARB_ID_W = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} uart_arb_state_t;
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin winner search starting after last_i.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]       mask_i,
  input  logic [UART_ARB_ID_W-1:0] last_i,
  output logic                     any_o,
  output logic [UART_ARB_ID_W-1:0] win_o
);
  int idx;
  // Descending scan so the closest candidate after last_i is written last and wins.
  always_comb begin
    any_o = |mask_i;
    win_o = '0;
    idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (mask_i[idx]) win_o = UART_ARB_ID_W'(idx);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding byte streams into one shared uart_tx.
// Define UART_ARB_LOCK_EN to keep packets contiguous (lock per packet, capped at BURST_MAX bytes).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           uart_tx_busy,
  output logic                           uart_tx_en,
  output logic [UART_BYTE_W-1:0]         uart_tx_data,
  output logic [UART_ARB_ID_W-1:0]       grant_id
);
  localparam int IW = UART_ARB_ID_W;
  localparam int BW = UART_BYTE_W;
  uart_arb_state_t    state_q, state_d;
  logic [NUM_REQ-1:0] ready_q, ready_d, elig;
  logic               en_q, en_d, any;
  logic [BW-1:0]      data_q, data_d;
  logic [IW-1:0]      grant_q, grant_d, last_q, last_d, win;
`ifdef UART_ARB_LOCK_EN
  localparam int CW = $clog2(BURST_MAX + 1);
  logic          lock_q, lock_d, blast_q, blast_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  assign elig    = lock_q ? req_valid & (NUM_REQ'(1) << grant_q) : req_valid;
  assign cnt_inc = cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q  <= 1'b0;
      blast_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      blast_q <= blast_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign elig       = req_valid;
  assign unused_cfg = ^{req_last, BURST_MAX > 0};
`endif
  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .mask_i(elig),
    .last_i(last_q),
    .any_o (any),
    .win_o (win)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ready_q <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
  // A grantee that withdraws before its accept pulse is dropped without sending.
  always_comb begin
    state_d = state_q;
    ready_d = '0;
    en_d    = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
    blast_d = blast_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (!uart_tx_busy && any) begin
        ready_d = NUM_REQ'(1) << win;
        data_d  = req_data[{win, 3'b000} +: BW];
        grant_d = win;
        last_d  = win;
        state_d = ISSUE;
`ifdef UART_ARB_LOCK_EN
        blast_d = req_last[win];
`endif
      end
      ISSUE: if (req_valid[grant_q]) begin
        en_d    = 1'b1;
        state_d = WAIT_BUSY;
`ifdef UART_ARB_LOCK_EN
        lock_d  = !(blast_q || cnt_inc == CW'(BURST_MAX));
        cnt_d   = lock_d ? cnt_inc : '0;
`endif
      end else begin
        state_d = IDLE;
      end
      WAIT_BUSY: state_d = uart_tx_busy ? WAIT_DONE : WAIT_BUSY;
      default:   state_d = uart_tx_busy ? WAIT_DONE : IDLE;
    endcase
  end
  assign req_ready    = ready_q & req_valid;
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign grant_id     = grant_q;
endmodule
